// File: rtl/acc_cpu_core_if.sv
// Memory port of acc_cpu_core: request/ready handshake that tolerates wait states.
interface acc_cpu_core_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
);
  logic          MemReq;
  logic          MemWe;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemD;
  logic [DW-1:0] MemQ;
  logic          MemRdy;

  modport master (
    output MemReq, MemWe, MemAddr, MemD,
    input  MemQ, MemRdy
  );

  modport slave (
    input  MemReq, MemWe, MemAddr, MemD,
    output MemQ, MemRdy
  );
endinterface

// File: rtl/acc_cpu_core.sv
// Multicycle accumulator CPU: FETCH -> DECODE -> (MEM) with Z/C flags and a
// request/ready memory port.
module acc_cpu_core #(
  parameter int unsigned   DW       = 16,
  parameter int unsigned   AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic           Clk,
  input  logic           Rst,
  acc_cpu_core_if.master bus,
  output logic           Halted,
  output logic [DW-1:0]  AccOut,
  output logic [AW-1:0]  PcOut
);

  typedef enum logic [1:0] {StFetch, StDecode, StMem, StHalt} stateE;

  stateE         state;
  logic [AW-1:0] pc;
  logic [DW-1:0] acc;
  logic [DW-1:0] ir;
  logic          zFlag;
  logic          cFlag;

  logic [3:0]    opcode;
  logic [AW-1:0] operand;
  logic [DW:0]   sum;
  logic [DW:0]   diff;
  logic [DW-1:0] aluRes;
  logic          aluC;

  assign opcode  = ir[DW-1:DW-4];
  assign operand = ir[AW-1:0];

  if (DW > AW + 4) begin : gIrSpare
    logic unusedIr;
    assign unusedIr = ^ir[DW-5:AW];
  end

  // Bit DW of the widened difference is the borrow.
  assign sum  = {1'b0, acc} + {1'b0, bus.MemQ};
  assign diff = {1'b0, acc} - {1'b0, bus.MemQ};

  always_comb begin
    aluRes = acc;
    aluC   = cFlag;
    case (opcode)
      4'h1: aluRes = bus.MemQ;
      4'h3: begin aluRes = sum[DW-1:0];  aluC = sum[DW];  end
      4'h4: begin aluRes = diff[DW-1:0]; aluC = diff[DW]; end
      4'h5: aluRes = acc & bus.MemQ;
      4'h6: aluRes = acc | bus.MemQ;
      4'h7: aluRes = acc ^ bus.MemQ;
      4'h8: aluRes = ~acc;
      4'hC: aluRes = {{(DW-AW){1'b0}}, operand};
      4'hD: begin aluRes = {acc[DW-2:0], 1'b0}; aluC = acc[DW-1]; end
      4'hE: begin aluRes = {1'b0, acc[DW-1:1]}; aluC = acc[0];    end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= StFetch;
      pc    <= RESET_PC;
      acc   <= '0;
      ir    <= '0;
      zFlag <= 1'b0;
      cFlag <= 1'b0;
    end else begin
      case (state)
        StFetch: begin
          if (bus.MemRdy) begin
            ir    <= bus.MemQ;
            pc    <= pc + AW'(1);
            state <= StDecode;
          end
        end
        StDecode: begin
          state <= StFetch;
          case (opcode)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: state <= StMem;
            4'h8, 4'hC, 4'hD, 4'hE: begin
              acc   <= aluRes;
              zFlag <= (aluRes == '0);
              cFlag <= aluC;
            end
            4'h9: pc <= operand;
            4'hA: if (zFlag) pc <= operand;
            4'hB: if (cFlag) pc <= operand;
            4'hF: state <= StHalt;
            default: ;
          endcase
        end
        StMem: begin
          if (bus.MemRdy) begin
            if (opcode != 4'h2) begin
              acc   <= aluRes;
              zFlag <= (aluRes == '0);
              cFlag <= aluC;
            end
            state <= StFetch;
          end
        end
        default: state <= StHalt;
      endcase
    end
  end

  // Reset forces the port quiet so an aborted request never completes.
  always_comb begin
    bus.MemReq  = 1'b0;
    bus.MemWe   = 1'b0;
    bus.MemAddr = '0;
    bus.MemD    = '0;
    Halted      = 1'b0;
    if (Rst) begin
      bus.MemReq  = (state == StFetch) || (state == StMem);
      bus.MemWe   = (state == StMem) && (opcode == 4'h2);
      bus.MemAddr = (state == StMem) ? operand : pc;
      bus.MemD    = acc;
      Halted      = (state == StHalt);
    end
  end

  assign AccOut = acc;
  assign PcOut  = pc;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Scoreboard bench for acc_cpu_core: expected memory writes are queued by the
// stimulus and popped by per-port monitors; end state is checked at HALT.
module tb_acc_cpu_core;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wrT;

  logic clk  = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  always #5 clk = ~clk;

  int cycAbs = 0;
  int start0 = 0;
  int start1 = 0;
  always @(posedge clk) cycAbs <= cycAbs + 1;

  int nCmp  = 0;
  int nFail = 0;

  wrT exp0[$];
  wrT exp1[$];

  task automatic check(input string name, input longint act, input longint req);
    nCmp++;
    if (act != req) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // ---------------- DUT0: DW=16, AW=8 ----------------
  acc_cpu_core_if #(.DW(16), .AW(8)) bus0 ();
  logic        halted0;
  logic [15:0] acc0;
  logic [7:0]  pc0;

  acc_cpu_core #(.DW(16), .AW(8), .RESET_PC(8'h00)) dut0 (
    .Clk    (clk),
    .Rst    (rst0),
    .bus    (bus0),
    .Halted (halted0),
    .AccOut (acc0),
    .PcOut  (pc0)
  );

  logic [15:0] mem0 [256];
  int          wait0   = 0;
  int          waitCnt0 = 0;
  bit          stallWr = 1'b0;

  assign bus0.MemQ   = mem0[bus0.MemAddr];
  assign bus0.MemRdy = bus0.MemReq && !(stallWr && bus0.MemWe) && (waitCnt0 == wait0);

  always @(posedge clk) begin
    if (bus0.MemReq && bus0.MemRdy) begin
      if (bus0.MemWe) mem0[bus0.MemAddr] = bus0.MemD;
      waitCnt0 <= 0;
    end else if (bus0.MemReq) begin
      waitCnt0 <= waitCnt0 + 1;
    end else begin
      waitCnt0 <= 0;
    end
  end

  logic        prevPend0 = 1'b0;
  logic [24:0] prevReq0  = '0;

  always @(negedge clk) begin
    wrT e;
    if (rst0 && bus0.MemReq && bus0.MemWe && bus0.MemRdy) begin
      if (exp0.size() == 0) begin
        check("wr0 unexpected", longint'(bus0.MemAddr), -1);
      end else begin
        e = exp0.pop_front();
        check("wr0 addr", longint'(bus0.MemAddr), longint'(e.addr));
        check("wr0 data", longint'(bus0.MemD), longint'(e.data));
        if (e.cyc >= 0) check("wr0 cycle", longint'(cycAbs - start0), longint'(e.cyc));
      end
    end
    if (prevPend0 && bus0.MemReq)
      check("req0 held", longint'({bus0.MemAddr, bus0.MemWe, bus0.MemD}), longint'(prevReq0));
    prevPend0 = rst0 && bus0.MemReq && !bus0.MemRdy;
    prevReq0  = {bus0.MemAddr, bus0.MemWe, bus0.MemD};
  end

  // ---------------- DUT1: DW=24, AW=12 ----------------
  acc_cpu_core_if #(.DW(24), .AW(12)) bus1 ();
  logic        halted1;
  logic [23:0] acc1;
  logic [11:0] pc1;

  acc_cpu_core #(.DW(24), .AW(12), .RESET_PC(12'hFFE)) dut1 (
    .Clk    (clk),
    .Rst    (rst1),
    .bus    (bus1),
    .Halted (halted1),
    .AccOut (acc1),
    .PcOut  (pc1)
  );

  logic [23:0] mem1 [4096];
  assign bus1.MemQ   = mem1[bus1.MemAddr];
  assign bus1.MemRdy = bus1.MemReq;

  always @(posedge clk) begin
    if (bus1.MemReq && bus1.MemRdy && bus1.MemWe) mem1[bus1.MemAddr] = bus1.MemD;
  end

  always @(negedge clk) begin
    wrT e;
    if (rst1 && bus1.MemReq && bus1.MemWe && bus1.MemRdy) begin
      if (exp1.size() == 0) begin
        check("wr1 unexpected", longint'(bus1.MemAddr), -1);
      end else begin
        e = exp1.pop_front();
        check("wr1 addr", longint'(bus1.MemAddr), longint'(e.addr));
        check("wr1 data", longint'(bus1.MemD), longint'(e.data));
        check("wr1 cycle", longint'(cycAbs - start1), longint'(e.cyc));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear0();
    for (int i = 0; i < 256; i++) mem0[i] = 16'h0000;
  endtask

  task automatic pushWr0(input int addr, input int data, input int cyc);
    wrT e;
    e.addr = addr;
    e.data = data;
    e.cyc  = cyc;
    exp0.push_back(e);
  endtask

  task automatic run0(input string tag, input int waits, input int haltCyc,
                      input logic [15:0] accExp, input logic [7:0] pcExp);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    rst0  = 1'b0;
    wait0 = waits;
    @(posedge clk);
    @(negedge clk);
    check({tag, " rst outputs"},
          longint'({bus0.MemReq, bus0.MemWe, bus0.MemAddr, bus0.MemD, halted0}), 0);
    check({tag, " rst acc/pc"}, longint'({acc0, pc0}), 0);
    @(posedge clk);
    #1 rst0 = 1'b1;
    start0 = cycAbs;
    @(negedge clk);
    check({tag, " first fetch"}, longint'({bus0.MemReq, bus0.MemWe, bus0.MemAddr}),
          longint'({1'b1, 1'b0, 8'h00}));
    while (n < 400 && !done) begin
      @(negedge clk);
      if (halted0) done = 1'b1;
      else n++;
    end
    check({tag, " halt reached"}, longint'(done), 1);
    if (done) begin
      if (haltCyc >= 0) check({tag, " halt cycle"}, longint'(cycAbs - start0), longint'(haltCyc));
      check({tag, " acc"}, longint'(acc0), longint'(accExp));
      check({tag, " pc"}, longint'(pc0), longint'(pcExp));
      repeat (2) @(negedge clk);
      check({tag, " req after halt"}, longint'({bus0.MemReq, halted0}), longint'(2'b01));
    end
    check({tag, " writes drained"}, longint'(exp0.size()), 0);
  endtask

  task automatic loadAdd();
    clear0();
    mem0[8'h00] = 16'h1010;
    mem0[8'h01] = 16'h3011;
    mem0[8'h02] = 16'h2012;
    mem0[8'h03] = 16'hF000;
    mem0[8'h10] = 16'h0005;
    mem0[8'h11] = 16'h0007;
  endtask

  initial begin
    int n;
    bit seen;

    // Add program, no wait states
    loadAdd();
    pushWr0(8'h12, 16'h000C, 8);
    run0("add", 0, 11, 16'h000C, 8'h04);
    check("add mem[12]", longint'(mem0[8'h12]), 16'h000C);

    // Same program, two wait cycles on every request
    loadAdd();
    pushWr0(8'h12, 16'h000C, 20);
    run0("addwait", 2, 25, 16'h000C, 8'h04);

    // Carry/zero flags and conditional branches
    clear0();
    mem0[8'h00] = 16'hC0FF;
    for (int i = 1; i <= 8; i++) mem0[i] = 16'hD000;
    mem0[8'h09] = 16'h3030;
    mem0[8'h0A] = 16'hB020;
    mem0[8'h0B] = 16'hF000;
    mem0[8'h20] = 16'h2040;
    mem0[8'h21] = 16'hA025;
    mem0[8'h22] = 16'hF000;
    mem0[8'h25] = 16'hC000;
    mem0[8'h26] = 16'h4031;
    mem0[8'h27] = 16'h2041;
    mem0[8'h28] = 16'hA02B;
    mem0[8'h29] = 16'hB02C;
    mem0[8'h2A] = 16'hF000;
    mem0[8'h2B] = 16'hF000;
    mem0[8'h2C] = 16'hF000;
    mem0[8'h30] = 16'h0100;
    mem0[8'h31] = 16'h0001;
    pushWr0(8'h40, 16'h0000, -1);
    pushWr0(8'h41, 16'hFFFF, -1);
    run0("flags", 0, 42, 16'hFFFF, 8'h2D);

    // Untaken JZ, JMP 0xFF then PC wrap to 0x00
    clear0();
    mem0[8'h00] = 16'hA005;
    mem0[8'h01] = 16'hC000;
    mem0[8'h02] = 16'h90FF;
    mem0[8'h05] = 16'hC077;
    mem0[8'h06] = 16'h2050;
    mem0[8'h07] = 16'hF000;
    pushWr0(8'h50, 16'h0077, 14);
    run0("wrap", 0, 17, 16'h0077, 8'h08);

    // Reset while an STA is stalled
    clear0();
    mem0[8'h00] = 16'hC033;
    mem0[8'h01] = 16'h2060;
    mem0[8'h02] = 16'hF000;
    mem0[8'h60] = 16'hBEEF;
    stallWr = 1'b1;
    wait0   = 0;
    rst0    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst0 = 1'b1;
    start0 = cycAbs;
    n    = 0;
    seen = 1'b0;
    while (n < 30 && !seen) begin
      @(negedge clk);
      if (bus0.MemReq && bus0.MemWe) seen = 1'b1;
      else n++;
    end
    check("abort sta pending", longint'(seen), 1);
    repeat (2) @(negedge clk);
    rst0 = 1'b0;
    #1;
    check("abort req in rst cycle", longint'({bus0.MemReq, bus0.MemWe}), 0);
    @(posedge clk);
    #1 stallWr = 1'b0;
    @(negedge clk);
    check("abort acc/pc", longint'({acc0, pc0}), 0);
    check("abort no write", longint'(mem0[8'h60]), 16'hBEEF);
    pushWr0(8'h60, 16'h0033, 4);
    run0("restart", 0, 7, 16'h0033, 8'h03);

    // 24-bit data / 12-bit address build
    for (int i = 0; i < 4096; i++) mem1[i] = 24'h000000;
    mem1[12'hFFE] = 24'h100ABC;
    mem1[12'hFFF] = 24'h300ABD;
    mem1[12'h000] = 24'h200010;
    mem1[12'h001] = 24'hF00000;
    mem1[12'hABC] = 24'hFFFFF0;
    mem1[12'hABD] = 24'h000015;
    begin
      wrT e;
      e.addr = 12'h010;
      e.data = 24'h000005;
      e.cyc  = 8;
      exp1.push_back(e);
    end
    rst1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("w24 rst acc/pc", longint'({acc1, pc1}), longint'({24'h0, 12'hFFE}));
    @(posedge clk);
    #1 rst1 = 1'b1;
    start1 = cycAbs;
    @(negedge clk);
    check("w24 first fetch", longint'({bus1.MemReq, bus1.MemAddr}), longint'({1'b1, 12'hFFE}));
    n    = 0;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      @(negedge clk);
      if (halted1) seen = 1'b1;
      else n++;
    end
    check("w24 halt reached", longint'(seen), 1);
    check("w24 halt cycle", longint'(cycAbs - start1), 11);
    check("w24 acc", longint'(acc1), 24'h000005);
    check("w24 pc", longint'(pc1), 12'h002);
    check("w24 mem[010]", longint'(mem1[12'h010]), 24'h000005);
    check("w24 writes drained", longint'(exp1.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
